pgm_rd: RTL and testbench
=========================

PGM_RD -- requirements
Module: pgm_rd

Interface
REQ-001 SHALL have parameter PLATFORM, default "xilinx", selecting the vendor target; it has no functional effect in this block.
REQ-002 SHALL have port clk, input, 1, the single clock for all logic.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port pgm_config_reset, input, 1, level; 1 = configuration in progress.
REQ-005 SHALL have port sent_ready, input, 1, level; 1 = all four streams are stored in RAM.
REQ-006 SHALL have port global_time, input, 64, free-running time in clk cycles.
REQ-007 SHALL have port table_entry_flag, input, 1, one-cycle strobe qualifying table_entry_data.
REQ-008 SHALL have port table_entry_data, input, 138: [137:74] start time, [73:10] rate (interval in cycles), [9:0] RAM base address (stream index << 7).
REQ-009 SHALL have port out_pgm_rd_raddr_wr, output, 1, RAM read enable.
REQ-010 SHALL have port out_pgm_rd_raddr, output, 10, RAM read address.
REQ-011 SHALL have port in_pgm_rd_data, input, 134, RAM read data, valid exactly one cycle after the address cycle.
REQ-012 SHALL have port in_pgm_data_ready, input, 1, downstream ready.
REQ-013 SHALL have port out_pgm_data, output, 134, packet word; [133:132] = 01 head, 10 tail, 11 body.
REQ-014 SHALL have port out_pgm_data_wr, output, 1, out_pgm_data valid strobe.
REQ-015 SHALL have port out_sent_pkt_cnt, output, 32, total packets sent since reset or config.

Function
REQ-016 SHALL hold a 4-entry table; each entry has valid, next_time[63:0], rate[63:0] and base[9:0].
REQ-017 SHALL, on a table_entry_flag cycle with data[9]==0, write entry data[8:7]: valid=1, next_time=start, rate=rate, base={data[9:7],7'b0}.
REQ-018 SHALL ignore table_entry_flag cycles with data[9]==1.
REQ-019 SHALL apply a rewrite of an existing entry on the cycle after the strobe, overriding any next_time update made in that cycle.
REQ-020 SHALL mark an entry due when it is valid and global_time >= next_time (unsigned 64-bit compare).
REQ-021 SHALL implement states IDLE, ARB, READ and DRAIN.
REQ-022 SHALL move IDLE -> ARB when pgm_config_reset==0 and sent_ready==1; otherwise stay in IDLE.
REQ-023 SHALL, in ARB, select the lowest-index due entry when in_pgm_data_ready==1, set next_time = next_time + rate (modulo 2^64) and go to READ.
REQ-024 SHALL stay in ARB when no entry is due or in_pgm_data_ready==0, and go to IDLE when the IDLE entry condition drops.
REQ-025 SHALL treat rate==0 as sending the stream at every ARB opportunity.
REQ-026 SHALL, in READ, assert out_pgm_rd_raddr_wr every cycle with addresses base, base+1, ... and keep a 7-bit word counter.
REQ-027 SHALL register each returned word onto out_pgm_data/out_pgm_data_wr, so output lags its address by 2 cycles.
REQ-028 SHALL, when a returned word has [133:132]==10, stop issuing reads from that cycle and discard the one already-issued overfetch word (no out_pgm_data_wr for it).
REQ-029 SHALL, if 128 words are issued with no tail, stop at address base+127, output all 128 words unchanged and go to DRAIN.
REQ-030 SHALL, in DRAIN, wait until the last valid word is output, increment out_sent_pkt_cnt by 1 (wrapping at 2^32) and go to ARB.
REQ-031 SHALL sample in_pgm_data_ready only in ARB, so a packet in progress is never stalled.
REQ-032 SHALL, when pgm_config_reset==1, clear every valid bit and out_sent_pkt_cnt at once.
REQ-033 SHALL, when pgm_config_reset rises mid-packet, finish the packet through DRAIN without counting it and then go to IDLE.
REQ-034 SHALL drive out_pgm_data to 0 whenever out_pgm_data_wr==0.

Reset
REQ-035 SHALL, on rst_n==0 asynchronously, set state=IDLE, all valid bits=0, all next_time, rate and base=0, out_pgm_rd_raddr_wr=0, out_pgm_rd_raddr=0, out_pgm_data=0, out_pgm_data_wr=0 and out_sent_pkt_cnt=0.

Verification
REQ-036 SHALL cover: entry 0 with start=100, rate=50 and a 4-word packet at address 0, sent_ready=1 -> heads output at global_time 102, 152 and 202; raddr 0..4 issued each time; exactly 4 wr strobes per packet.
REQ-037 SHALL cover: entries 1 and 3 both due at t=10 -> stream 1 (raddr 128) sent first, then stream 3 (raddr 384) with no gap beyond ARB; out_sent_pkt_cnt=2.
REQ-038 SHALL cover: in_pgm_data_ready=0 while due, then 1 -> no raddr_wr while low; the packet starts in the cycle after ARB samples ready=1.
REQ-039 SHALL cover: a stored packet with no tail -> 128 reads (raddr 0..127), 128 outputs, then return to ARB.
REQ-040 SHALL cover: pgm_config_reset pulse on word 2 of a 6-word packet -> all 6 words still output, out_sent_pkt_cnt=0, no further reads until new entries arrive and sent_ready=1.
REQ-041 SHALL cover: rst_n asserted mid-READ -> all outputs 0 in the same cycle, state IDLE, table empty.

Source files
------------

// File: rtl/pgm_rd.sv
// Scheduled packet reader: up to four RAM-resident streams, each replayed at its own
// start time and interval, one packet at a time, onto the downstream word bus.

module pgm_rd_entry (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        wr,
  input  logic        adv,
  input  logic [63:0] wr_start,
  input  logic [63:0] wr_rate,
  input  logic [9:0]  wr_base,
  input  logic [63:0] global_time,
  output logic        due,
  output logic [9:0]  base
);
  logic        valid;
  logic [63:0] next_time;
  logic [63:0] rate;

  // A table write lands after any schedule advance so a rewrite always wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid     <= 1'b0;
      next_time <= '0;
      rate      <= '0;
      base      <= '0;
    end else begin
      if (clr) valid <= 1'b0;
      if (adv) next_time <= next_time + rate;
      if (wr) begin
        valid     <= 1'b1;
        next_time <= wr_start;
        rate      <= wr_rate;
        base      <= wr_base;
      end
    end
  end

  assign due = valid && (global_time >= next_time);
endmodule

module pgm_rd #(
  parameter PLATFORM = "xilinx"
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         pgm_config_reset,
  input  logic         sent_ready,
  input  logic [63:0]  global_time,
  input  logic         table_entry_flag,
  input  logic [137:0] table_entry_data,
  output logic         out_pgm_rd_raddr_wr,
  output logic [9:0]   out_pgm_rd_raddr,
  input  logic [133:0] in_pgm_rd_data,
  input  logic         in_pgm_data_ready,
  output logic [133:0] out_pgm_data,
  output logic         out_pgm_data_wr,
  output logic [31:0]  out_sent_pkt_cnt
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ARB   = 2'd1;
  localparam logic [1:0] READ  = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  logic [1:0]       state;
  logic [6:0]       cnt;
  logic             rd_vld;
  logic             abort;
  logic             wr_pend;
  logic [63:0]      wr_start;
  logic [63:0]      wr_rate;
  logic [2:0]       wr_hi;
  logic [3:0]       due;
  logic [3:0]       adv;
  logic [3:0]       ent_wr;
  logic [3:0][9:0]  ent_base;
  logic [1:0]       sel_idx;
  logic             go;
  logic             arb_fire;
  logic             tail_now;
  logic             unused_ok;

  assign unused_ok = &{1'b0, table_entry_data[6:0], (PLATFORM == "xilinx")};

  assign go       = !pgm_config_reset && sent_ready;
  assign arb_fire = (state == ARB) && go && in_pgm_data_ready && (|due);
  assign tail_now = rd_vld && (in_pgm_rd_data[133:132] == 2'b10);

  always_comb begin
    sel_idx = '0;
    for (int i = 3; i >= 0; i--)
      if (due[i]) sel_idx = 2'(i);
  end

  generate
    for (genvar i = 0; i < 4; i++) begin : g_ent
      assign ent_wr[i] = wr_pend && (wr_hi[1:0] == 2'(i));
      assign adv[i]    = arb_fire && (sel_idx == 2'(i));
      pgm_rd_entry u_ent (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (pgm_config_reset),
        .wr          (ent_wr[i]),
        .adv         (adv[i]),
        .wr_start    (wr_start),
        .wr_rate     (wr_rate),
        .wr_base     ({wr_hi, 7'd0}),
        .global_time (global_time),
        .due         (due[i]),
        .base        (ent_base[i])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= IDLE;
      cnt                 <= '0;
      rd_vld              <= 1'b0;
      abort               <= 1'b0;
      wr_pend             <= 1'b0;
      wr_start            <= '0;
      wr_rate             <= '0;
      wr_hi               <= '0;
      out_pgm_rd_raddr_wr <= 1'b0;
      out_pgm_rd_raddr    <= '0;
      out_pgm_data        <= '0;
      out_pgm_data_wr     <= 1'b0;
      out_sent_pkt_cnt    <= '0;
    end else begin
      wr_pend <= table_entry_flag && !table_entry_data[9];
      if (table_entry_flag) begin
        wr_start <= table_entry_data[137:74];
        wr_rate  <= table_entry_data[73:10];
        wr_hi    <= table_entry_data[9:7];
      end
      // The read issued alongside a returned tail is the overfetch; never mark it valid.
      rd_vld          <= out_pgm_rd_raddr_wr && !tail_now;
      out_pgm_data_wr <= rd_vld;
      out_pgm_data    <= rd_vld ? in_pgm_rd_data : '0;
      if (pgm_config_reset && (state == READ || state == DRAIN)) abort <= 1'b1;
      if (pgm_config_reset) out_sent_pkt_cnt <= '0;

      case (state)
        IDLE: if (go) state <= ARB;
        ARB: begin
          if (!go) state <= IDLE;
          else if (arb_fire) begin
            state               <= READ;
            out_pgm_rd_raddr_wr <= 1'b1;
            out_pgm_rd_raddr    <= ent_base[sel_idx];
            cnt                 <= '0;
          end
        end
        READ: begin
          if (tail_now || cnt == 7'd127) begin
            out_pgm_rd_raddr_wr <= 1'b0;
            state               <= DRAIN;
          end else begin
            out_pgm_rd_raddr <= out_pgm_rd_raddr + 10'd1;
            cnt              <= cnt + 7'd1;
          end
        end
        default: begin
          if (!rd_vld) begin
            abort <= 1'b0;
            if (abort || pgm_config_reset) state <= IDLE;
            else begin
              out_sent_pkt_cnt <= out_sent_pkt_cnt + 32'd1;
              state            <= ARB;
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_pgm_rd.sv
// Directed bench for pgm_rd: RAM model, event monitor and hand-derived expectations.
// Times are labelled by the global_time the DUT sampled at the edge that loaded a register.

module tb_pgm_rd;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         pgm_config_reset;
  logic         sent_ready;
  logic [63:0]  global_time;
  logic         table_entry_flag;
  logic [137:0] table_entry_data;
  logic         raddr_wr;
  logic [9:0]   raddr;
  logic [133:0] rd_data = '0;
  logic         ready;
  logic [133:0] out_data;
  logic         out_wr;
  logic [31:0]  pkt_cnt;

  logic [63:0]  cyc = '0;
  logic [63:0]  gt_off = '0;
  logic [133:0] mem [0:1023];
  logic [9:0]   raddr_q [$];
  logic [63:0]  rt_q [$];
  logic [63:0]  ht_q [$];
  logic [133:0] od_q [$];
  int           zero_err = 0;
  int           tests = 0;
  int           fails = 0;
  int           err;

  pgm_rd #(.PLATFORM("xilinx")) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .pgm_config_reset    (pgm_config_reset),
    .sent_ready          (sent_ready),
    .global_time         (global_time),
    .table_entry_flag    (table_entry_flag),
    .table_entry_data    (table_entry_data),
    .out_pgm_rd_raddr_wr (raddr_wr),
    .out_pgm_rd_raddr    (raddr),
    .in_pgm_rd_data      (rd_data),
    .in_pgm_data_ready   (ready),
    .out_pgm_data        (out_data),
    .out_pgm_data_wr     (out_wr),
    .out_sent_pkt_cnt    (pkt_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 64'd1;
  assign global_time = cyc - gt_off;

  always @(posedge clk) rd_data <= raddr_wr ? mem[raddr] : '0;

  // global_time has already advanced past the edge being observed, hence the -1.
  always @(negedge clk) if (rst_n) begin
    if (raddr_wr) begin
      raddr_q.push_back(raddr);
      rt_q.push_back(global_time - 64'd1);
    end
    if (out_wr) begin
      od_q.push_back(out_data);
      if (out_data[133:132] == 2'b01) ht_q.push_back(global_time - 64'd1);
    end
    if (!out_wr && out_data != '0) zero_err++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [133:0] w(input logic [1:0] t, input logic [31:0] p);
    return {t, 100'd0, p};
  endfunction

  function automatic logic [137:0] ent(input logic [63:0] s, input logic [63:0] r, input logic [2:0] hi);
    return {s, r, hi, 7'd0};
  endfunction

  task automatic check(input string tag, input logic [133:0] obs, input logic [133:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wr_ent(input logic [137:0] d);
    table_entry_flag = 1'b1;
    table_entry_data = d;
    tick(1);
    table_entry_flag = 1'b0;
    table_entry_data = '0;
  endtask

  task automatic clear_q();
    raddr_q.delete(); rt_q.delete(); ht_q.delete(); od_q.delete();
  endtask

  task automatic cfg_pulse();
    pgm_config_reset = 1'b1;
    tick(1);
    pgm_config_reset = 1'b0;
  endtask

  task automatic run_to(input logic [63:0] t);
    for (int k = 0; k < 2000 && global_time != t; k++) tick(1);
    check("wait_time", global_time, t);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem[0] = w(2'b01, 32'h1000); mem[1] = w(2'b11, 32'h1001);
    mem[2] = w(2'b11, 32'h1002); mem[3] = w(2'b10, 32'h1003);
    mem[4] = w(2'b01, 32'hdead);
    mem[128] = w(2'b01, 32'h2000); mem[129] = w(2'b11, 32'h2001);
    mem[130] = w(2'b10, 32'h2002); mem[131] = w(2'b01, 32'hbad1);
    mem[384] = w(2'b01, 32'h3000); mem[385] = w(2'b10, 32'h3001);
    mem[386] = w(2'b01, 32'hbad3);
    mem[256] = w(2'b01, 32'h4000);
    for (int i = 257; i < 384; i++) mem[i] = w(2'b11, 32'h4000 + 32'(i));

    rst_n = 1'b0; pgm_config_reset = 1'b0; sent_ready = 1'b0; ready = 1'b0;
    table_entry_flag = 1'b0; table_entry_data = '0;
    tick(3);
    check("rst_raddr_wr", raddr_wr, 0);
    check("rst_raddr", raddr, 0);
    check("rst_data", out_data, 0);
    check("rst_wr", out_wr, 0);
    check("rst_cnt", pkt_cnt, 0);
    rst_n = 1'b1;
    tick(2);

    // periodic stream 0: start 100, every 50 cycles, 4-word packet
    gt_off = cyc;
    sent_ready = 1'b1; ready = 1'b1;
    wr_ent(ent(64'd100, 64'd50, 3'b000));
    run_to(64'd230);
    sent_ready = 1'b0;
    check("t1_head0", ht_q.size() > 0 ? ht_q[0] : 0, 102);
    check("t1_head1", ht_q.size() > 1 ? ht_q[1] : 0, 152);
    check("t1_head2", ht_q.size() > 2 ? ht_q[2] : 0, 202);
    check("t1_nreads", raddr_q.size(), 15);
    check("t1_nwr", od_q.size(), 12);
    err = 0;
    foreach (raddr_q[i]) if (raddr_q[i] !== 10'(i % 5)) err++;
    foreach (od_q[i]) if (od_q[i] !== mem[i % 4]) err++;
    check("t1_content", err, 0);
    check("t1_cnt", pkt_cnt, 3);

    // streams 1 and 3 due together; a data[9]==1 strobe must be ignored
    tick(5);
    cfg_pulse();
    check("cfg_cnt_clr", pkt_cnt, 0);
    clear_q();
    gt_off = cyc;
    wr_ent(ent(64'd10, 64'd1000, 3'b001));
    wr_ent(ent(64'd10, 64'd1000, 3'b011));
    wr_ent(ent(64'd0, 64'd0, 3'b101));
    sent_ready = 1'b1;
    run_to(64'd40);
    check("t2_nreads", raddr_q.size(), 7);
    check("t2_first", raddr_q.size() > 0 ? raddr_q[0] : 0, 128);
    check("t2_first_t", rt_q.size() > 0 ? rt_q[0] : 0, 10);
    check("t2_second", raddr_q.size() > 4 ? raddr_q[4] : 0, 384);
    check("t2_second_t", rt_q.size() > 4 ? rt_q[4] : 0, 16);
    check("t2_head1_t", ht_q.size() > 1 ? ht_q[1] : 0, 18);
    check("t2_nwr", od_q.size(), 5);
    check("t2_last", od_q.size() > 4 ? od_q[4] : 0, mem[385]);
    check("t2_cnt", pkt_cnt, 2);

    // downstream not ready while due
    sent_ready = 1'b0;
    cfg_pulse();
    clear_q();
    ready = 1'b0;
    gt_off = cyc;
    wr_ent(ent(64'd5, 64'd1000, 3'b000));
    sent_ready = 1'b1;
    run_to(64'd20);
    check("t3_noread", raddr_q.size(), 0);
    ready = 1'b1;
    run_to(64'd40);
    check("t3_start_t", rt_q.size() > 0 ? rt_q[0] : 0, 20);
    check("t3_nreads", raddr_q.size(), 5);
    check("t3_nwr", od_q.size(), 4);
    check("t3_cnt", pkt_cnt, 1);

    // 128-word packet with no tail, then the next period proves ARB was re-entered
    sent_ready = 1'b0;
    cfg_pulse();
    clear_q();
    gt_off = cyc;
    wr_ent(ent(64'd0, 64'd200, 3'b010));
    sent_ready = 1'b1;
    run_to(64'd180);
    check("t4_nreads", raddr_q.size(), 128);
    check("t4_lastaddr", raddr_q.size() > 0 ? raddr_q[raddr_q.size()-1] : 0, 383);
    check("t4_nwr", od_q.size(), 128);
    err = 0;
    foreach (raddr_q[i]) if (raddr_q[i] !== 10'(256 + i)) err++;
    foreach (od_q[i]) if (od_q[i] !== mem[256 + i]) err++;
    check("t4_content", err, 0);
    check("t4_cnt", pkt_cnt, 1);
    run_to(64'd215);
    check("t4_again_t", rt_q.size() > 128 ? rt_q[128] : 0, 200);
    sent_ready = 1'b0;
    cfg_pulse();
    tick(150);

    // config pulse on word 2 of a 6-word packet
    mem[128] = w(2'b01, 32'h5000);
    for (int i = 129; i < 133; i++) mem[i] = w(2'b11, 32'h5000 + 32'(i));
    mem[133] = w(2'b10, 32'h5005); mem[134] = w(2'b01, 32'hbad5);
    clear_q();
    gt_off = cyc;
    wr_ent(ent(64'd5, 64'd1000, 3'b001));
    sent_ready = 1'b1;
    for (int k = 0; k < 100 && od_q.size() < 2; k++) tick(1);
    check("t5_wait", od_q.size() >= 2, 1);
    cfg_pulse();
    run_to(64'd60);
    check("t5_nwr", od_q.size(), 6);
    check("t5_tail", od_q.size() > 5 ? od_q[5] : 0, mem[133]);
    check("t5_nreads", raddr_q.size(), 7);
    check("t5_cnt", pkt_cnt, 0);
    gt_off = cyc;
    wr_ent(ent(64'd5, 64'd1000, 3'b001));
    run_to(64'd40);
    check("t5_resume", raddr_q.size(), 14);
    check("t5_cnt2", pkt_cnt, 1);

    // asynchronous reset in the middle of a long read
    clear_q();
    gt_off = cyc;
    wr_ent(ent(64'd2, 64'd1000, 3'b010));
    for (int k = 0; k < 100 && raddr_q.size() < 10; k++) tick(1);
    check("t6_inread", raddr_wr, 1);
    rst_n = 1'b0;
    #1;
    check("t6_raddr_wr", raddr_wr, 0);
    check("t6_raddr", raddr, 0);
    check("t6_data", out_data, 0);
    check("t6_wr", out_wr, 0);
    check("t6_cnt", pkt_cnt, 0);
    tick(2);
    rst_n = 1'b1;
    clear_q();
    tick(60);
    check("t6_table_empty", raddr_q.size(), 0);
    check("t6_no_out", od_q.size(), 0);

    check("data_zero_idle", zero_err, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
